act_input_encoder: RTL and testbench

- Producer end of the 4-bit `act` move interface consumed by the tile-puzzle play controller.
- Conditions four raw push-buttons: 2-flop sync, per-button debounce, rising-edge detect, priority encode. Emits registered single-cycle one-hot `act` pulses.
- Also contains a scramble sequencer. On request it emits a fixed-length pseudo-random series of `act` pulses to shuffle the board.
- Sits between the board I/O pins and the play controller, in the `clk_d` domain.

---
 rtl/act_input_encoder.sv | 171 +++++++++++++++++
 tb/tb_act_input_encoder.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/act_input_encoder.sv
// Producer for the 4-bit act move interface of the tile-puzzle play controller.
// Raw buttons are synchronised, debounced, edge-detected and priority encoded
// into registered one-hot act pulses. A scramble sequencer can instead emit a
// fixed-length pseudo-random series of act pulses to shuffle the board.
module act_input_encoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned SCRAMBLE_LEN    = 32,
  parameter int unsigned SCRAMBLE_GAP    = 2,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic       clk_d,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] btn,
  input  logic       scramble_req,
  output logic [3:0] act,
  output logic       busy,
  output logic       scramble_done,
  output logic [7:0] press_count
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned GapW = $clog2(SCRAMBLE_GAP + 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [GapW-1:0] GapInit = GapW'(SCRAMBLE_GAP - 1);
  localparam logic [7:0]      LenInit = 8'(SCRAMBLE_LEN);
  localparam logic [15:0]     LfsrTaps = 16'hB400;

  typedef enum logic [1:0] {
    StIdle,
    StEmit,
    StGap,
    StDone
  } state_e;

  // Input conditioning state
  logic [3:0]      sync1_q, sync2_q;
  logic [3:0]      stable_q, stable_d;
  logic [3:0]      stable_dly_q;
  logic [CntW-1:0] cnt_q [4];
  logic [CntW-1:0] cnt_d [4];

  // Sequencer and output state
  state_e          state_q, state_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic [7:0]      remaining_q, remaining_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic [3:0]      act_q, act_d;
  logic            done_q, done_d;
  logic [7:0]      count_q, count_d;

  logic [3:0]      press;
  logic [3:0]      press_sel;
  logic [15:0]     lfsr_step;

  // Per-button debounce: a differing synced level must persist DEBOUNCE_CYCLES cycles.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      stable_d[i] = stable_q[i];
      cnt_d[i]    = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Rising edges of the debounced levels; lowest index wins, others are dropped.
  always_comb begin
    press     = stable_q & ~stable_dly_q;
    press_sel = press & (~press + 4'd1);
  end

  // One Galois step, right shift.
  always_comb begin
    lfsr_step = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LfsrTaps : 16'h0000);
  end

  // Scramble sequencer and output selection.
  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    remaining_d = remaining_q;
    gap_d       = gap_q;
    act_d       = 4'b0000;
    done_d      = 1'b0;
    count_d     = count_q;
    unique case (state_q)
      StIdle: begin
        if (start && scramble_req) begin
          state_d     = StEmit;
          remaining_d = LenInit;
          count_d     = 8'd0;
        end else if (start && (|press)) begin
          act_d   = press_sel;
          count_d = count_q + 8'd1;
        end
      end
      StEmit: begin
        // Pulses are suppressed, not paused, when start drops mid-scramble.
        act_d       = start ? (4'b0001 << lfsr_q[1:0]) : 4'b0000;
        lfsr_d      = lfsr_step;
        remaining_d = remaining_q - 8'd1;
        gap_d       = GapInit;
        state_d     = StGap;
      end
      StGap: begin
        if (gap_q == '0) begin
          if (remaining_q == 8'd0) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            state_d = StEmit;
          end
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // All state, with synchronous active-high reset.
  always_ff @(posedge clk_d) begin
    if (reset) begin
      sync1_q      <= 4'b0000;
      sync2_q      <= 4'b0000;
      stable_q     <= 4'b0000;
      stable_dly_q <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
      state_q     <= StIdle;
      lfsr_q      <= LFSR_SEED;
      remaining_q <= 8'd0;
      gap_q       <= '0;
      act_q       <= 4'b0000;
      done_q      <= 1'b0;
      count_q     <= 8'd0;
    end else begin
      sync1_q      <= btn;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      remaining_q <= remaining_d;
      gap_q       <= gap_d;
      act_q       <= act_d;
      done_q      <= done_d;
      count_q     <= count_d;
    end
  end

  assign act           = act_q;
  assign busy          = (state_q != StIdle);
  assign scramble_done = done_q;
  assign press_count   = count_q;

endmodule

// File: tb/tb_act_input_encoder.sv
// Self-checking bench for act_input_encoder with a small debounce and scramble
// configuration. Expected per-cycle outputs are queued when stimulus is driven
// and popped as the DUT advances.
module tb_act_input_encoder;

  localparam int unsigned DB  = 4;
  localparam int unsigned LEN = 4;
  localparam int unsigned GAP = 2;

  logic       clk_d = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] btn;
  logic       scramble_req;
  logic [3:0] act;
  logic       busy;
  logic       scramble_done;
  logic [7:0] press_count;

  typedef struct packed {
    logic [3:0] act;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t        exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] m_lfsr;
  logic [7:0]  exp_count;

  always #5 clk_d = ~clk_d;

  act_input_encoder #(
    .DEBOUNCE_CYCLES(DB),
    .SCRAMBLE_LEN   (LEN),
    .SCRAMBLE_GAP   (GAP),
    .LFSR_SEED      (16'hACE1)
  ) dut (
    .clk_d        (clk_d),
    .reset        (reset),
    .start        (start),
    .btn          (btn),
    .scramble_req (scramble_req),
    .act          (act),
    .busy         (busy),
    .scramble_done(scramble_done),
    .press_count  (press_count)
  );

  task automatic tick;
    @(posedge clk_d);
    #1;
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic test_reset;
    reset        = 1'b1;
    start        = 1'b0;
    btn          = 4'b0000;
    scramble_req = 1'b0;
    m_lfsr       = 16'hACE1;
    exp_count    = 8'd0;
    tick();
    tick();
    vectors++;
    if ({act, busy, scramble_done, press_count} !== 15'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: act=%b busy=%b done=%b count=%0d, expected all 0",
               act, busy, scramble_done, press_count);
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if ({act, busy, scramble_done, press_count} !== 15'd0) begin
        miscompares++;
        $display("FAIL post_reset_idle: act=%b busy=%b done=%b count=%0d, expected all 0",
                 act, busy, scramble_done, press_count);
      end
    end
  endtask

  // Single held button: one pulse at edge DB+2, none afterwards while held.
  task automatic test_debounce_latency;
    exp_t e;
    start = 1'b1;
    btn   = 4'b0010;
    for (int i = 0; i < 12; i++) begin
      e.act  = (i == DB + 2) ? 4'b0010 : 4'b0000;
      e.busy = 1'b0;
      e.done = 1'b0;
      exp_q.push_back(e);
    end
    exp_count = exp_count + 8'd1;
    for (int i = 0; i < 12; i++) begin
      tick();
      e = exp_q.pop_front();
      vectors++;
      if (act !== e.act) begin
        miscompares++;
        $display("FAIL latency_edge%0d: act=%b expected %b", i, act, e.act);
      end
    end
    vectors++;
    if (press_count !== exp_count) begin
      miscompares++;
      $display("FAIL latency_count: press_count=%0d expected %0d", press_count, exp_count);
    end
    btn = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      tick();
      vectors++;
      if (act !== 4'b0000) begin
        miscompares++;
        $display("FAIL release_quiet: act=%b expected 0000", act);
      end
    end
  endtask

  // Pulses shorter than DB cycles must never be accepted.
  task automatic test_glitch;
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 6; i++) begin
        btn = (i < 3) ? 4'b0001 : 4'b0000;
        tick();
        vectors++;
        if (act !== 4'b0000) begin
          miscompares++;
          $display("FAIL glitch_rep%0d_cyc%0d: act=%b expected 0000", r, i, act);
        end
      end
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      vectors++;
      if (act !== 4'b0000) begin
        miscompares++;
        $display("FAIL glitch_tail: act=%b expected 0000", act);
      end
    end
    vectors++;
    if (press_count !== exp_count) begin
      miscompares++;
      $display("FAIL glitch_count: press_count=%0d expected %0d", press_count, exp_count);
    end
  endtask

  // Simultaneous presses: lowest index wins, the other is dropped.
  task automatic test_simultaneous;
    exp_t       e;
    logic [3:0] pat [2];
    logic [3:0] want [2];
    pat[0]  = 4'b1010;
    want[0] = 4'b0010;
    pat[1]  = 4'b1000;
    want[1] = 4'b1000;
    for (int p = 0; p < 2; p++) begin
      btn = pat[p];
      for (int i = 0; i < 12; i++) begin
        e.act  = (i == DB + 2) ? want[p] : 4'b0000;
        e.busy = 1'b0;
        e.done = 1'b0;
        exp_q.push_back(e);
      end
      exp_count = exp_count + 8'd1;
      for (int i = 0; i < 12; i++) begin
        tick();
        e = exp_q.pop_front();
        vectors++;
        if (act !== e.act) begin
          miscompares++;
          $display("FAIL simul_p%0d_edge%0d: act=%b expected %b", p, i, act, e.act);
        end
      end
      btn = 4'b0000;
      for (int i = 0; i < 10; i++) begin
        tick();
        vectors++;
        if (act !== 4'b0000) begin
          miscompares++;
          $display("FAIL simul_release: act=%b expected 0000", act);
        end
      end
    end
    vectors++;
    if (press_count !== exp_count) begin
      miscompares++;
      $display("FAIL simul_count: press_count=%0d expected %0d", press_count, exp_count);
    end
  endtask

  // One full scramble from IDLE; optionally presses btn[2] while busy.
  task automatic run_scramble(input bit with_btn, input string name);
    exp_t e;
    int   n;
    n = 3 * LEN + 3;
    start        = 1'b1;
    scramble_req = 1'b1;
    if (with_btn) btn = 4'b0100;
    for (int i = 0; i < n; i++) begin
      e.act = 4'b0000;
      if (i >= 1 && ((i - 1) % (GAP + 1)) == 0 && ((i - 1) / (GAP + 1)) < LEN) begin
        e.act  = 4'b0001 << m_lfsr[1:0];
        m_lfsr = lfsr_next(m_lfsr);
      end
      e.busy = (i <= 3 * LEN);
      e.done = (i == 3 * LEN);
      exp_q.push_back(e);
    end
    exp_count = 8'd0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (i == 0) scramble_req = 1'b0;
      e = exp_q.pop_front();
      vectors++;
      if (act !== e.act) begin
        miscompares++;
        $display("FAIL %s_act_edge%0d: act=%b expected %b", name, i, act, e.act);
      end
      vectors++;
      if (busy !== e.busy) begin
        miscompares++;
        $display("FAIL %s_busy_edge%0d: busy=%b expected %b", name, i, busy, e.busy);
      end
      vectors++;
      if (scramble_done !== e.done) begin
        miscompares++;
        $display("FAIL %s_done_edge%0d: done=%b expected %b", name, i, scramble_done, e.done);
      end
      vectors++;
      if (press_count !== exp_count) begin
        miscompares++;
        $display("FAIL %s_count_edge%0d: press_count=%0d expected %0d",
                 name, i, press_count, exp_count);
      end
    end
    btn = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      tick();
      vectors++;
      if (act !== 4'b0000 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL %s_after: act=%b busy=%b expected 0000/0", name, act, busy);
      end
    end
  endtask

  task automatic test_scramble;
    run_scramble(1'b1, "scramble");
  endtask

  // 256 accepted presses wrap the counter; a following scramble keeps it at 0.
  task automatic test_wrap;
    int seen;
    int bad;
    for (int p = 0; p < 256; p++) begin
      seen = 0;
      bad  = 0;
      for (int i = 0; i < 16; i++) begin
        btn = (i < 8) ? 4'b0001 : 4'b0000;
        tick();
        if (act === 4'b0001) seen++;
        else if (act !== 4'b0000) bad++;
      end
      exp_count = exp_count + 8'd1;
      vectors++;
      if (seen != 1 || bad != 0) begin
        miscompares++;
        $display("FAIL wrap_press%0d: pulses=%0d stray=%0d expected 1/0", p, seen, bad);
      end
      if (p == 254 || p == 255) begin
        vectors++;
        if (press_count !== exp_count) begin
          miscompares++;
          $display("FAIL wrap_count%0d: press_count=%0d expected %0d", p, press_count, exp_count);
        end
      end
    end
    run_scramble(1'b0, "wrap_scramble");
  endtask

  // Reset during GAP after the second pulse aborts silently and restores the seed.
  task automatic test_reset_mid;
    logic [15:0] ml;
    logic [3:0]  want;
    ml           = m_lfsr;
    start        = 1'b1;
    scramble_req = 1'b1;
    tick();
    scramble_req = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      want = 4'b0000;
      if (i == 1 || i == 4) begin
        want = 4'b0001 << ml[1:0];
        ml   = lfsr_next(ml);
      end
      vectors++;
      if (act !== want) begin
        miscompares++;
        $display("FAIL abort_pre_edge%0d: act=%b expected %b", i, act, want);
      end
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if ({act, busy, scramble_done, press_count} !== 15'd0) begin
      miscompares++;
      $display("FAIL abort_reset: act=%b busy=%b done=%b count=%0d, expected all 0",
               act, busy, scramble_done, press_count);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      vectors++;
      if (scramble_done !== 1'b0 || busy !== 1'b0 || act !== 4'b0000) begin
        miscompares++;
        $display("FAIL abort_quiet: act=%b busy=%b done=%b expected 0000/0/0",
                 act, busy, scramble_done);
      end
    end
    m_lfsr    = 16'hACE1;
    exp_count = 8'd0;
    run_scramble(1'b0, "reseed_scramble");
  endtask

  initial begin
    test_reset();
    test_debounce_latency();
    test_glitch();
    test_simultaneous();
    test_scramble();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
